// File: rtl/rat_intr_pkg.sv
// Shared types and defaults for the interrupt controller: debounce state
// encoding, default parameters and the saturating counter helper.
package rat_intr_pkg;

    typedef enum logic [1:0] {
        ST_LO      = 2'd0,
        ST_WAIT_HI = 2'd1,
        ST_HI      = 2'd2,
        ST_WAIT_LO = 2'd3
    } db_state_e;

    localparam int DEBOUNCE_CYCLES_DEF = 4;
    localparam int SYNC_STAGES_DEF     = 2;
    localparam int CNT_W               = 8;

    // Saturating increment: the debounce count must never wrap back to zero.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        if (value == 8'hFF) begin
            return value;
        end else begin
            return value + 8'd1;
        end
    endfunction

endpackage

// File: rtl/db_fsm.sv
// Input synchronizer plus four-state debouncer for the external interrupt
// line. Produces the debounced level and a one-cycle rising-event pulse.
module db_fsm
    import rat_intr_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int SYNC_STAGES     = SYNC_STAGES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic irq_raw,
    output logic level,
    output logic rise_evt
);

    localparam logic [CNT_W-1:0] DB_LIMIT = 8'(DEBOUNCE_CYCLES);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   irq_sync_s;
    db_state_e              state_r;
    db_state_e              state_next_s;
    logic [CNT_W-1:0]       count_r;
    logic [CNT_W-1:0]       count_next_s;
    logic                   level_r;
    logic                   level_next_s;
    logic                   rise_evt_r;
    logic                   rise_next_s;

    assign irq_sync_s = sync_r[SYNC_STAGES-1];
    assign level      = level_r;
    assign rise_evt   = rise_evt_r;

    // Synchronizer chain; the only place irq_raw is sampled.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_r <= {SYNC_STAGES{1'b0}};
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], irq_raw};
        end
    end

    // State register with registered level and event outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_LO;
            count_r    <= 8'd0;
            level_r    <= 1'b0;
            rise_evt_r <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            count_r    <= count_next_s;
            level_r    <= level_next_s;
            rise_evt_r <= rise_next_s;
        end
    end

    // Next-state logic; count holds the run length of the opposing level.
    always_comb begin
        state_next_s = state_r;
        count_next_s = count_r;
        case (state_r)
            ST_LO: begin
                if (irq_sync_s) begin
                    if (DB_LIMIT == 8'd1) begin
                        state_next_s = ST_HI;
                        count_next_s = 8'd0;
                    end else begin
                        state_next_s = ST_WAIT_HI;
                        count_next_s = 8'd1;
                    end
                end else begin
                    count_next_s = 8'd0;
                end
            end
            ST_WAIT_HI: begin
                if (irq_sync_s) begin
                    if (sat_inc(count_r) >= DB_LIMIT) begin
                        state_next_s = ST_HI;
                        count_next_s = 8'd0;
                    end else begin
                        count_next_s = sat_inc(count_r);
                    end
                end else begin
                    state_next_s = ST_LO;
                    count_next_s = 8'd0;
                end
            end
            ST_HI: begin
                if (!irq_sync_s) begin
                    if (DB_LIMIT == 8'd1) begin
                        state_next_s = ST_LO;
                        count_next_s = 8'd0;
                    end else begin
                        state_next_s = ST_WAIT_LO;
                        count_next_s = 8'd1;
                    end
                end else begin
                    count_next_s = 8'd0;
                end
            end
            ST_WAIT_LO: begin
                if (!irq_sync_s) begin
                    if (sat_inc(count_r) >= DB_LIMIT) begin
                        state_next_s = ST_LO;
                        count_next_s = 8'd0;
                    end else begin
                        count_next_s = sat_inc(count_r);
                    end
                end else begin
                    state_next_s = ST_HI;
                    count_next_s = 8'd0;
                end
            end
            default: begin
                state_next_s = ST_LO;
                count_next_s = 8'd0;
            end
        endcase
    end

    // Output decode; returning from ST_WAIT_LO to ST_HI is not a new event.
    always_comb begin
        level_next_s = 1'b0;
        rise_next_s  = 1'b0;
        case (state_next_s)
            ST_HI, ST_WAIT_LO: level_next_s = 1'b1;
            default:           level_next_s = 1'b0;
        endcase
        if ((state_r == ST_LO || state_r == ST_WAIT_HI) && state_next_s == ST_HI) begin
            rise_next_s = 1'b1;
        end else begin
            rise_next_s = 1'b0;
        end
    end

endmodule

// File: rtl/intr_ctrl.sv
// Interrupt controller top: debounced external request latched as a single
// pending event, gated by the interrupt-enable mask towards the control unit.
module intr_ctrl
    import rat_intr_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int SYNC_STAGES     = SYNC_STAGES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic irq_raw,
    input  logic i_set,
    input  logic i_clr,
    input  logic intr_ack,
    output logic interrupt,
    output logic i_en,
    output logic pending
);

    logic db_level_unused_s;
    logic rise_evt_s;
    logic pending_r;
    logic pending_next_s;
    logic ien_r;
    logic ien_next_s;
    logic interrupt_r;

    db_fsm #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .SYNC_STAGES     (SYNC_STAGES)
    ) u_db_fsm (
        .clk      (clk),
        .reset    (reset),
        .irq_raw  (irq_raw),
        .level    (db_level_unused_s),
        .rise_evt (rise_evt_s)
    );

    assign pending   = pending_r;
    assign i_en      = ien_r;
    assign interrupt = interrupt_r;

    // Next values: a new event beats a same-cycle ack, and clear beats set.
    always_comb begin
        pending_next_s = rise_evt_s | (pending_r & ~intr_ack);
        if (i_clr) begin
            ien_next_s = 1'b0;
        end else if (i_set) begin
            ien_next_s = 1'b1;
        end else begin
            ien_next_s = ien_r;
        end
    end

    // Pending, mask and request registers; interrupt always equals pending & i_en.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending_r   <= 1'b0;
            ien_r       <= 1'b0;
            interrupt_r <= 1'b0;
        end else begin
            pending_r   <= pending_next_s;
            ien_r       <= ien_next_s;
            interrupt_r <= pending_next_s & ien_next_s;
        end
    end

endmodule

// File: tb/tb_intr_ctrl.sv
// Scoreboard bench for intr_ctrl: a behavioural model predicts outputs per
// cycle, plus directed latency and collision checks.
module tb_intr_ctrl;
    import rat_intr_pkg::*;

    localparam int DB = DEBOUNCE_CYCLES_DEF;
    localparam int SS = SYNC_STAGES_DEF;

    logic clk = 1'b0;
    logic reset, irq_raw, i_set, i_clr, intr_ack;
    logic interrupt, i_en, pending;

    intr_ctrl #(.DEBOUNCE_CYCLES(DB), .SYNC_STAGES(SS)) dut (
        .clk       (clk),
        .reset     (reset),
        .irq_raw   (irq_raw),
        .i_set     (i_set),
        .i_clr     (i_clr),
        .intr_ack  (intr_ack),
        .interrupt (interrupt),
        .i_en      (i_en),
        .pending   (pending)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic intr;
        logic pend;
        logic ien;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;

    // Model: input delayed by SS flops; level flips once the last DB samples all disagree.
    logic [SS-1:0] m_pipe;
    logic [DB-1:0] m_hist;
    logic m_lvl, m_evt, m_pend, m_ien, m_int;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_step(input logic r, input logic irq, input logic s,
                              input logic c, input logic a);
        logic consumed;
        logic flip;
        logic evt_new;
        exp_t e;
        if (r) begin
            m_pipe = '0; m_hist = '0;
            m_lvl = 1'b0; m_evt = 1'b0; m_pend = 1'b0; m_ien = 1'b0; m_int = 1'b0;
        end else begin
            consumed = m_pipe[SS-1];
            m_pipe   = {m_pipe[SS-2:0], irq};
            m_hist   = {m_hist[DB-2:0], consumed};
            flip     = (m_hist == {DB{~m_lvl}});
            evt_new  = flip & ~m_lvl;
            if (flip) m_lvl = ~m_lvl;
            m_pend = m_evt | (m_pend & ~a);
            m_evt  = evt_new;
            m_ien  = c ? 1'b0 : (s ? 1'b1 : m_ien);
            m_int  = m_pend & m_ien;
        end
        e.intr = m_int;
        e.pend = m_pend;
        e.ien  = m_ien;
        sb_q.push_back(e);
    endtask

    task automatic drive(input logic r, input logic irq, input logic s,
                         input logic c, input logic a);
        @(negedge clk);
        reset = r; irq_raw = irq; i_set = s; i_clr = c; intr_ack = a;
        model_step(r, irq, s, c, a);
    endtask

    task automatic hold(input logic irq, input int n);
        for (int i = 0; i < n; i++) drive(1'b0, irq, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic sample;
        @(posedge clk);
        #2;
    endtask

    // Holds irq_raw high and reports the first edge at which the watched output rises.
    task automatic watch_first(input string tag, input logic use_pend,
                               input int exp_edge, input int max_edges);
        int first;
        first = 0;
        for (int i = 1; i <= max_edges; i++) begin
            drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
            sample();
            if (first == 0 && (use_pend ? pending : interrupt)) first = i;
        end
        chk(tag, 32'(first), 32'(exp_edge));
    endtask

    // Scoreboard monitor: compare each cycle's outputs against the model.
    always @(posedge clk) begin
        #1;
        if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            chk("sb_interrupt", 32'(interrupt), 32'(mon_e.intr));
            chk("sb_pending",   32'(pending),   32'(mon_e.pend));
            chk("sb_i_en",      32'(i_en),      32'(mon_e.ien));
        end
    end

    initial begin
        reset = 1'b1; irq_raw = 1'b0; i_set = 1'b0; i_clr = 1'b0; intr_ack = 1'b0;
        repeat (3) drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        sample();
        chk("rst_interrupt", 32'(interrupt), 32'd0);
        chk("rst_pending",   32'(pending),   32'd0);
        chk("rst_i_en",      32'(i_en),      32'd0);

        // Clean press with interrupts enabled.
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        watch_first("press_latency", 1'b0, SS + DB + 1, 12);
        hold(1'b1, 8);
        hold(1'b0, 8);
        sample();
        chk("press_held", 32'(interrupt), 32'd1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        sample();
        chk("press_ack_pending",   32'(pending),   32'd0);
        chk("press_ack_interrupt", 32'(interrupt), 32'd0);

        // Bounce: 3 high / 1 low three times, then stable high.
        hold(1'b0, 4);
        for (int k = 0; k < 3; k++) begin
            hold(1'b1, 3);
            hold(1'b0, 1);
        end
        watch_first("bounce_latency", 1'b1, SS + DB + 1, 12);
        hold(1'b1, 4);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        hold(1'b1, 6);
        sample();
        chk("bounce_single", 32'(pending), 32'd0);
        hold(1'b0, 10);

        // Masked press, then unmask.
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        watch_first("mask_pending", 1'b1, SS + DB + 1, 12);
        chk("mask_interrupt", 32'(interrupt), 32'd0);
        chk("mask_i_en",      32'(i_en),      32'd0);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        sample();
        chk("mask_unmask", 32'(interrupt), 32'd1);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        hold(1'b0, 10);

        // Collisions: ack during the event cycle, set and clear together.
        hold(1'b1, SS + DB);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        sample();
        chk("coll_event_ack", 32'(pending), 32'd1);
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        sample();
        chk("coll_set_clr_ien", 32'(i_en),      32'd0);
        chk("coll_set_clr_int", 32'(interrupt), 32'd0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        hold(1'b0, 10);

        // Reset at count 2 in ST_WAIT_HI with irq_raw held high.
        hold(1'b1, 4);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        sample();
        chk("rst_mid_interrupt", 32'(interrupt), 32'd0);
        chk("rst_mid_pending",   32'(pending),   32'd0);
        chk("rst_mid_i_en",      32'(i_en),      32'd0);
        watch_first("rst_relatency", 1'b1, SS + DB + 1, 12);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        hold(1'b1, 10);
        sample();
        chk("rst_single_event", 32'(pending), 32'd0);
        hold(1'b0, 10);

        // Two presses merge into one pending request.
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        hold(1'b1, 10);
        hold(1'b0, 10);
        hold(1'b1, 10);
        hold(1'b0, 10);
        sample();
        chk("two_pending", 32'(pending), 32'd1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        sample();
        chk("two_ack_clear", 32'(pending), 32'd0);
        hold(1'b0, 5);
        sample();
        chk("two_stay_clear", 32'(pending), 32'd0);

        repeat (3) @(posedge clk);
        #2;
        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
